// File: rtl/br_pkg.sv
// Shared branch-resolve definitions: funct3 encodings, FSM states, drain defaults.
// No logic; constants and types only.
// Imported by br_cond_decode and branch_resolve_unit.
package br_pkg;

  // Conditional-branch funct3 encodings (010/011 are reserved)
  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  // Redirect/flush sequencer states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REDIR = 2'd1,
    ST_DRAIN = 2'd2
  } br_state_t;

  // Drain window: up to 15 cycles, held in a 4-bit down-counter
  localparam int DRAIN_W              = 4;
  localparam int DEFAULT_DRAIN_CYCLES = 2;

endpackage

// File: rtl/br_cond_decode.sv
// Branch condition decode: funct3 + comparator flags -> BrUn select, taken, illegal.
// Latency: purely combinational. No handshake.
// Ports: funct3 in; br_lt/br_eq in from comparator; br_un, taken, illegal out.
module br_cond_decode
  import br_pkg::*;
(
  input  logic [2:0] funct3,
  input  logic       br_lt,
  input  logic       br_eq,
  output logic       br_un,
  output logic       taken,
  output logic       illegal
);

  // Only the *U variants request the unsigned comparison (br_un=0).
  assign br_un = !((funct3 == F3_BLTU) || (funct3 == F3_BGEU));

  always_comb begin
    taken   = 1'b0;
    illegal = 1'b0;
    case (funct3)
      F3_BEQ:           taken = br_eq;
      F3_BNE:           taken = !br_eq;
      F3_BLT,  F3_BLTU: taken = br_lt;
      F3_BGE,  F3_BGEU: taken = !br_lt;
      default:          illegal = 1'b1;  // 010/011: never taken
    endcase
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// EX-stage branch resolution: checks condition against fetch prediction, issues PC redirect.
// Latency: all effects registered, visible one cycle after the resolve cycle.
// Backpressure: redirect held until redirect_ready; ex_ready=0 through redirect and drain.
// Ports: clk/rst_n; ex_* EX slot inputs; BrLt/BrEq/BrUn comparator link;
//        redirect_valid/redirect_pc/redirect_ready to IF; flush; exception pulses; perf counters.
module branch_resolve_unit
  import br_pkg::*;
#(
  parameter int XLEN         = 32,
  parameter int DRAIN_CYCLES = DEFAULT_DRAIN_CYCLES,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ex_valid,
  input  logic             ex_branch,
  input  logic [2:0]       ex_funct3,
  input  logic [XLEN-1:0]  ex_pc,
  input  logic [XLEN-1:0]  ex_target,
  input  logic             ex_pred_taken,
  input  logic             BrLt,
  input  logic             BrEq,
  output logic             BrUn,
  output logic             ex_ready,
  output logic             redirect_valid,
  output logic [XLEN-1:0]  redirect_pc,
  input  logic             redirect_ready,
  output logic             flush,
  output logic             misalign_exc,
  output logic             illegal_br,
  output logic [CNT_W-1:0] br_count,
  output logic [CNT_W-1:0] mispred_count
);

  localparam logic [DRAIN_W-1:0] DRAIN_LOAD = DRAIN_W'(DRAIN_CYCLES);

  br_state_t          state, state_nxt;
  logic [DRAIN_W-1:0] drain_cnt, drain_cnt_nxt;

  logic taken, illegal;
  logic resolve, misalign, mispred;

  br_cond_decode u_decode (
    .funct3  (ex_funct3),
    .br_lt   (BrLt),
    .br_eq   (BrEq),
    .br_un   (BrUn),
    .taken   (taken),
    .illegal (illegal)
  );

  // Outside IDLE the EX slot holds wrong-path instructions; they never resolve.
  assign resolve  = ex_valid && ex_branch && (state == ST_IDLE);
  // Priority: illegal > misaligned target > mispredict > correct.
  assign misalign = taken && (ex_target[1:0] != 2'b00);
  assign mispred  = !illegal && !misalign && (taken != ex_pred_taken);

  // Handshake-facing outputs come straight from the state register.
  assign ex_ready       = (state == ST_IDLE);
  assign redirect_valid = (state == ST_REDIR);
  assign flush          = (state != ST_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      drain_cnt <= '0;
    end else begin
      state     <= state_nxt;
      drain_cnt <= drain_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    drain_cnt_nxt = drain_cnt;
    case (state)
      ST_IDLE: begin
        if (resolve && mispred) state_nxt = ST_REDIR;
      end
      ST_REDIR: begin
        if (redirect_ready) begin
          if (DRAIN_LOAD == '0) begin
            state_nxt = ST_IDLE;
          end else begin
            state_nxt     = ST_DRAIN;
            drain_cnt_nxt = DRAIN_LOAD;
          end
        end
      end
      ST_DRAIN: begin
        // Each DRAIN cycle consumes one count, so DRAIN lasts exactly DRAIN_CYCLES cycles.
        drain_cnt_nxt = drain_cnt - DRAIN_W'(1);
        if (drain_cnt_nxt == '0) state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt     = ST_IDLE;
        drain_cnt_nxt = '0;
      end
    endcase
  end

  // Redirect PC is captured only on mispredict, so it stays stable while REDIR waits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      redirect_pc <= '0;
    end else if (resolve && mispred) begin
      redirect_pc <= taken ? ex_target : (ex_pc + XLEN'(4));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      misalign_exc <= 1'b0;
      illegal_br   <= 1'b0;
    end else begin
      misalign_exc <= resolve && !illegal && misalign;
      illegal_br   <= resolve && illegal;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      br_count      <= '0;
      mispred_count <= '0;
    end else if (resolve && !illegal) begin
      if (br_count != '1) br_count <= br_count + CNT_W'(1);
      if (mispred && (mispred_count != '1)) mispred_count <= mispred_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed testbench for branch_resolve_unit with hand-computed expectations.
// Inputs driven 1 time unit after each rising edge; outputs sampled at the same point.
// Ports of the DUT are all connected by name.
module tb_branch_resolve_unit;

  logic        clk;
  logic        rst_n;
  logic        ex_valid, ex_branch, ex_pred_taken;
  logic [2:0]  ex_funct3;
  logic [31:0] ex_pc, ex_target;
  logic        BrLt, BrEq, BrUn;
  logic        ex_ready, redirect_valid, redirect_ready, flush;
  logic [31:0] redirect_pc;
  logic        misalign_exc, illegal_br;
  logic [31:0] br_count, mispred_count;

  int checks   = 0;
  int failures = 0;

  branch_resolve_unit #(.XLEN(32), .DRAIN_CYCLES(2), .CNT_W(32)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .ex_valid       (ex_valid),
    .ex_branch      (ex_branch),
    .ex_funct3      (ex_funct3),
    .ex_pc          (ex_pc),
    .ex_target      (ex_target),
    .ex_pred_taken  (ex_pred_taken),
    .BrLt           (BrLt),
    .BrEq           (BrEq),
    .BrUn           (BrUn),
    .ex_ready       (ex_ready),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .redirect_ready (redirect_ready),
    .flush          (flush),
    .misalign_exc   (misalign_exc),
    .illegal_br     (illegal_br),
    .br_count       (br_count),
    .mispred_count  (mispred_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] f3, input logic lt, input logic eq, input logic pred,
                       input logic [31:0] pc, input logic [31:0] tgt);
    ex_valid      = 1'b1;
    ex_branch     = 1'b1;
    ex_funct3     = f3;
    BrLt          = lt;
    BrEq          = eq;
    ex_pred_taken = pred;
    ex_pc         = pc;
    ex_target     = tgt;
  endtask

  task automatic idle_in();
    ex_valid  = 1'b0;
    ex_branch = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    idle_in();
    ex_funct3 = 3'b000; BrLt = 1'b0; BrEq = 1'b0; ex_pred_taken = 1'b0;
    ex_pc = '0; ex_target = '0; redirect_ready = 1'b0;
    #2;
    chk("rst_ex_ready", 32'(ex_ready), 32'd1);
    chk("rst_redir_valid", 32'(redirect_valid), 32'd0);
    chk("rst_redir_pc", redirect_pc, 32'h0);
    chk("rst_flush", 32'(flush), 32'd0);
    chk("rst_br_count", br_count, 32'd0);
    chk("rst_mispred_count", mispred_count, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // 1: BEQ taken, predicted not-taken -> redirect to target
    drive(3'b000, 1'b0, 1'b1, 1'b0, 32'h100, 32'h200);
    #1 chk("t1_brun", 32'(BrUn), 32'd1);
    step();
    idle_in();
    chk("t1_redir_valid", 32'(redirect_valid), 32'd1);
    chk("t1_redir_pc", redirect_pc, 32'h200);
    chk("t1_flush", 32'(flush), 32'd1);
    chk("t1_ex_ready", 32'(ex_ready), 32'd0);
    chk("t1_mispred", mispred_count, 32'd1);
    chk("t1_br", br_count, 32'd1);
    redirect_ready = 1'b1;
    step();
    redirect_ready = 1'b0;
    chk("t1_drain1_valid", 32'(redirect_valid), 32'd0);
    chk("t1_drain1_flush", 32'(flush), 32'd1);
    step();
    chk("t1_drain2_flush", 32'(flush), 32'd1);
    step();
    chk("t1_idle_ready", 32'(ex_ready), 32'd1);
    chk("t1_idle_flush", 32'(flush), 32'd0);

    // 2: BLTU selects unsigned, BLT signed; both correctly predicted
    drive(3'b110, 1'b1, 1'b0, 1'b1, 32'h300, 32'h400);
    #1 chk("t2_bltu_brun", 32'(BrUn), 32'd0);
    step();
    chk("t2_bltu_noredir", 32'(redirect_valid), 32'd0);
    chk("t2_bltu_br", br_count, 32'd2);
    drive(3'b100, 1'b0, 1'b0, 1'b0, 32'h304, 32'h500);
    #1 chk("t2_blt_brun", 32'(BrUn), 32'd1);
    step();
    idle_in();
    chk("t2_blt_noredir", 32'(redirect_valid), 32'd0);
    chk("t2_blt_br", br_count, 32'd3);
    chk("t2_mispred", mispred_count, 32'd1);

    // 3+4: BNE not taken but predicted taken at top of memory -> pc+4 wraps to 0,
    // IF stalls 5 cycles while a wrong-path branch sits in EX
    drive(3'b001, 1'b0, 1'b1, 1'b1, 32'hFFFF_FFFC, 32'h800);
    step();
    drive(3'b000, 1'b0, 1'b1, 1'b0, 32'h900, 32'hA00);
    chk("t3_redir_pc", redirect_pc, 32'h0);
    chk("t3_mispred", mispred_count, 32'd2);
    for (int i = 0; i < 5; i++) begin
      chk("t4_stall_valid", 32'(redirect_valid), 32'd1);
      chk("t4_stall_pc", redirect_pc, 32'h0);
      chk("t4_stall_ready", 32'(ex_ready), 32'd0);
      step();
    end
    chk("t4_wrongpath_br", br_count, 32'd4);
    idle_in();
    redirect_ready = 1'b1;
    step();
    redirect_ready = 1'b0;
    chk("t4_drain1_flush", 32'(flush), 32'd1);
    chk("t4_drain1_valid", 32'(redirect_valid), 32'd0);
    step();
    chk("t4_drain2_flush", 32'(flush), 32'd1);
    chk("t4_drain2_ready", 32'(ex_ready), 32'd0);
    step();
    chk("t4_done_flush", 32'(flush), 32'd0);
    chk("t4_done_ready", 32'(ex_ready), 32'd1);
    chk("t4_mispred_kept", mispred_count, 32'd2);

    // 5: BGE taken to misaligned target; then reserved funct3
    drive(3'b101, 1'b0, 1'b0, 1'b1, 32'h600, 32'h202);
    step();
    idle_in();
    chk("t5_misalign", 32'(misalign_exc), 32'd1);
    chk("t5_mis_noredir", 32'(redirect_valid), 32'd0);
    chk("t5_mis_br", br_count, 32'd5);
    step();
    chk("t5_misalign_pulse", 32'(misalign_exc), 32'd0);
    drive(3'b011, 1'b1, 1'b1, 1'b1, 32'h700, 32'h800);
    step();
    idle_in();
    chk("t5_illegal", 32'(illegal_br), 32'd1);
    chk("t5_ill_noredir", 32'(redirect_valid), 32'd0);
    chk("t5_ill_br", br_count, 32'd5);
    step();
    chk("t5_illegal_pulse", 32'(illegal_br), 32'd0);

    // 6: ready already high -> accepted the cycle valid rises; reset during DRAIN
    redirect_ready = 1'b1;
    drive(3'b000, 1'b0, 1'b0, 1'b1, 32'h1000, 32'h2000);
    step();
    idle_in();
    chk("t6_redir_valid", 32'(redirect_valid), 32'd1);
    chk("t6_redir_pc", redirect_pc, 32'h1004);
    step();
    chk("t6_drain_valid", 32'(redirect_valid), 32'd0);
    chk("t6_drain_flush", 32'(flush), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_ready", 32'(ex_ready), 32'd1);
    chk("t6_rst_flush", 32'(flush), 32'd0);
    chk("t6_rst_pc", redirect_pc, 32'h0);
    chk("t6_rst_br", br_count, 32'd0);
    chk("t6_rst_mispred", mispred_count, 32'd0);
    redirect_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    step();
    drive(3'b000, 1'b0, 1'b1, 1'b1, 32'h40, 32'h80);
    step();
    idle_in();
    chk("t6_post_br", br_count, 32'd1);
    chk("t6_post_noredir", 32'(redirect_valid), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
